pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage CPU.
- Detects load-use hazards that forwarding (MEM/WB path only) cannot cover.
- Arbitrates the single shared memory port between I-cache and D-cache miss fills.
- Drives every pipeline-register write-enable, bubble and flush.
- Sits beside the forwarding unit and the hazard path between ID and EX.

---
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Detects load-use hazards, arbitrates the shared memory port between I- and D-cache fills,
// and drives all pipeline-register enables, bubbles and flushes.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned FILL_TIMEOUT = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_MemRead,
    input  logic [3:0]       ID_EX_Rd,
    input  logic [3:0]       IF_ID_Rs,
    input  logic [3:0]       IF_ID_Rt,
    input  logic             IF_ID_UseRt,
    input  logic             branch_taken,
    input  logic             halt,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic             mem_fill_done,
    output logic             mem_grant_i,
    output logic             mem_grant_d,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             back_write,
    output logic             halted,
`ifdef STALL_CNT_EN
    input  logic             stall_cnt_clr,
    output logic [CNT_W-1:0] stall_cycles,
`endif
    output logic             mem_err
);

    typedef enum logic [1:0] {StRun, StDfill, StIfill, StHalted} state_e;

    localparam logic [7:0] TimeoutLim = FILL_TIMEOUT[7:0];

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       load_use;
    logic [7:0] cnt_inc;

    // Raw outputs before the reset gate.
    logic grant_i_c, grant_d_c, pc_write_c, if_id_write_c, if_id_flush_c;
    logic id_ex_bubble_c, back_write_c, halted_c;

    // Register 0 is hardwired, so a load to it never creates a hazard.
    assign load_use = ID_EX_MemRead && (ID_EX_Rd != 4'd0) &&
                      ((ID_EX_Rd == IF_ID_Rs) || (IF_ID_UseRt && (ID_EX_Rd == IF_ID_Rt)));

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // State, fill-timeout counter and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, timeout bookkeeping and per-state pipeline controls.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        grant_i_c      = 1'b0;
        grant_d_c      = 1'b0;
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        back_write_c   = 1'b0;
        halted_c       = 1'b0;
        case (state_q)
            StRun: begin
                if (dcache_miss) begin
                    // D-side fill wins when both caches miss together.
                    state_d = StDfill;
                    cnt_d   = 8'd0;
                end else if (icache_miss) begin
                    state_d = StIfill;
                    cnt_d   = 8'd0;
                end else if (load_use) begin
                    // Hold PC and IF/ID for one cycle, inject one bubble behind the load.
                    id_ex_bubble_c = 1'b1;
                    back_write_c   = 1'b1;
                end else begin
                    pc_write_c    = 1'b1;
                    if_id_write_c = 1'b1;
                    back_write_c  = 1'b1;
                    if (branch_taken) begin
                        if_id_flush_c = 1'b1;
                    end else if (halt) begin
                        state_d = StHalted;
                    end
                end
            end
            StDfill: begin
                grant_d_c = 1'b1;
                if (mem_fill_done) begin
                    state_d = icache_miss ? StIfill : StRun;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutLim) err_d = 1'b1;
                end
            end
            StIfill: begin
                grant_i_c     = 1'b1;
                if_id_write_c = 1'b1;
                if_id_flush_c = 1'b1;
                // Back end drains unless a D-miss is now pending, which freezes it.
                back_write_c  = !dcache_miss;
                if (mem_fill_done) begin
                    state_d = dcache_miss ? StDfill : StRun;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutLim) err_d = 1'b1;
                end
            end
            StHalted: begin
                halted_c     = 1'b1;
                back_write_c = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    // Everything reads 0 while reset is asserted, independent of the clock.
    assign mem_grant_i  = rst_n & grant_i_c;
    assign mem_grant_d  = rst_n & grant_d_c;
    assign pc_write     = rst_n & pc_write_c;
    assign if_id_write  = rst_n & if_id_write_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_bubble = rst_n & id_ex_bubble_c;
    assign back_write   = rst_n & back_write_c;
    assign halted       = rst_n & halted_c;
    assign mem_err      = err_q;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Count cycles in which the front end is held, excluding the halted state.
    always_comb begin
        stall_d = stall_q;
        if (stall_cnt_clr) begin
            stall_d = '0;
        end else if (!pc_write_c && (state_q != StHalted) && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences
// and randomized stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int FT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mr = 1'b0, urt = 1'b0, br = 1'b0, hlt = 1'b0;
    logic [3:0] rd = '0, rs = '0, rt = '0;
    logic       im = 1'b0, dm = 1'b0, done = 1'b0;
    logic       gi, gd, pcw, ifw, ifl, bub, bkw, hld, err;
`ifdef STALL_CNT_EN
    logic        scl = 1'b0;
    logic [15:0] scnt;
`endif

    pipe_hazard_ctrl #(.FILL_TIMEOUT(FT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UseRt(urt),
        .branch_taken(br), .halt(hlt), .icache_miss(im), .dcache_miss(dm),
        .mem_fill_done(done),
        .mem_grant_i(gi), .mem_grant_d(gd), .pc_write(pcw), .if_id_write(ifw),
        .if_id_flush(ifl), .id_ex_bubble(bub), .back_write(bkw), .halted(hld),
`ifdef STALL_CNT_EN
        .stall_cnt_clr(scl), .stall_cycles(scnt),
`endif
        .mem_err(err)
    );

    always #5 clk = ~clk;

    // Output vector order: grant_i grant_d pc_write if_id_write flush bubble back halted err
    localparam logic [8:0] VRun    = 9'b001100100;
    localparam logic [8:0] VStall  = 9'b000001100;
    localparam logic [8:0] VBranch = 9'b001110100;
    localparam logic [8:0] VDfill  = 9'b010000000;
    localparam logic [8:0] VIfill  = 9'b100110100;
    localparam logic [8:0] VIfrz   = 9'b100110000;
    localparam logic [8:0] VHalt   = 9'b000000110;
    localparam logic [8:0] VZero   = 9'b000000000;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] obs;

    // Behavioural model: 0 run, 1 D fill, 2 I fill, 3 halted.
    int m_mode = 0;
    int m_wait = 0;
    bit m_err  = 1'b0;

    function automatic logic [8:0] sample();
        return {gi, gd, pcw, ifw, ifl, bub, bkw, hld, err};
    endfunction

    function automatic bit hazard();
        return mr && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
    endfunction

    function automatic logic [8:0] model_out();
        logic [8:0] v;
        if (!rst_n) return VZero;
        case (m_mode)
            0: v = (im || dm) ? VZero : hazard() ? VStall : br ? VBranch : VRun;
            1: v = VDfill;
            2: v = dm ? VIfrz : VIfill;
            default: v = VHalt;
        endcase
        v[0] = m_err;
        return v;
    endfunction

    task automatic model_step();
        if (m_mode == 0) begin
            if (dm)                          begin m_mode = 1; m_wait = 0; end
            else if (im)                     begin m_mode = 2; m_wait = 0; end
            else if (!hazard() && !br && hlt) m_mode = 3;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (done) begin
                m_mode = (m_mode == 1) ? (im ? 2 : 0) : (dm ? 1 : 0);
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait >= FT) m_err = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already driven; compare at negedge, advance model at posedge.
    task automatic cycle(input string name);
        @(negedge clk);
        obs = sample();
        check(name, obs, model_out());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", sample(), VZero);
        m_mode = 0; m_wait = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", sample(), VZero);
        rst_n = 1'b1;
    endtask

    task automatic clr_in();
        mr = 0; rd = 0; rs = 0; rt = 0; urt = 0; br = 0; hlt = 0; im = 0; dm = 0; done = 0;
    endtask

    typedef struct {
        logic       mr;
        logic [3:0] rd, rs, rt;
        logic       urt, br;
        logic [8:0] exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 4'd3,  4'd3,  4'd0,  1'b0, 1'b0, VStall};
        vt[1] = '{1'b1, 4'd0,  4'd0,  4'd0,  1'b1, 1'b0, VRun};
        vt[2] = '{1'b1, 4'd5,  4'd1,  4'd5,  1'b0, 1'b0, VRun};
        vt[3] = '{1'b1, 4'd5,  4'd1,  4'd5,  1'b1, 1'b0, VStall};
        vt[4] = '{1'b0, 4'd3,  4'd3,  4'd3,  1'b1, 1'b0, VRun};
        vt[5] = '{1'b0, 4'd2,  4'd3,  4'd4,  1'b1, 1'b1, VBranch};
        vt[6] = '{1'b1, 4'd7,  4'd7,  4'd0,  1'b0, 1'b1, VStall};
        vt[7] = '{1'b1, 4'd15, 4'd14, 4'd15, 1'b1, 1'b0, VStall};

        // Reset with noisy inputs present.
        br = 1'b1; dm = 1'b1;
        do_reset();
        clr_in();

        // Combinational vectors in RUN, each followed by a clean cycle.
        for (int i = 0; i < 8; i++) begin
            mr = vt[i].mr; rd = vt[i].rd; rs = vt[i].rs; rt = vt[i].rt;
            urt = vt[i].urt; br = vt[i].br;
            cycle("vec");
            check($sformatf("vec%0d", i), obs, vt[i].exp);
            clr_in();
            cycle("vec_after");
            check("vec_after", obs, VRun);
        end

        // Simultaneous misses: D first, then I, then back to RUN.
        im = 1; dm = 1;
        cycle("both_miss");  check("both_miss", obs, VZero);
        repeat (3) begin cycle("dfill"); check("dfill", obs, VDfill); end
        done = 1; cycle("dfill_done"); check("dfill_done", obs, VDfill);
        done = 0; dm = 0;
        repeat (2) begin cycle("ifill2"); check("ifill2", obs, VIfill); end
        done = 1; cycle("ifill2_done");
        done = 0; im = 0;
        cycle("run_after_fills"); check("run_after_fills", obs, VRun);

        // I-fill lasting four cycles drains the back end.
        im = 1;
        cycle("imiss"); check("imiss", obs, VZero);
        for (int i = 0; i < 4; i++) begin
            done = (i == 3);
            cycle("ifill_drain"); check("ifill_drain", obs, VIfill);
        end
        done = 0; im = 0;
        cycle("drain_end"); check("drain_end_no_err", obs, VRun);

        // D-miss raised during an I-fill freezes the back end and follows with a D-fill.
        im = 1;
        cycle("imiss2");
        dm = 1;
        cycle("ifill_frz"); check("ifill_frz", obs, VIfrz);
        done = 1; cycle("ifill_frz_done");
        done = 0; im = 0;
        cycle("dfill_after"); check("dfill_after", obs, VDfill);
        done = 1; cycle("dfill_after_done");
        done = 0; dm = 0;
        cycle("run2"); check("run2", obs, VRun);

        // Fill timeout: mem_err appears after FT fill cycles and stays.
        dm = 1;
        cycle("dmiss_to");
        for (int i = 1; i <= 9; i++) begin
            cycle("to_wait");
            check($sformatf("to_err_c%0d", i), {8'd0, obs[0]}, {8'd0, (i == 9)});
        end
        done = 1; cycle("to_done");
        done = 0; dm = 0;
        cycle("to_run"); check("to_sticky", obs, VRun | 9'b1);

        // Halt: HALTED next cycle, ignores fill-done, left only by reset.
        hlt = 1;
        cycle("halt_req"); check("halt_req", obs, VRun | 9'b1);
        hlt = 0;
        for (int i = 0; i < 3; i++) begin
            done = (i == 1);
            cycle("halted"); check("halted", obs, VHalt | 9'b1);
        end
        done = 0;
        do_reset();
        cycle("post_halt_reset"); check("post_halt_reset", obs, VRun);

        // Reset in the middle of a D-fill drops grants asynchronously.
        dm = 1;
        cycle("dmiss_rst");
        cycle("dfill_rst"); check("dfill_rst", obs, VDfill);
        do_reset();
        dm = 0;
        cycle("run_after_rst"); check("run_after_rst", obs, VRun);

        // Randomized run against the model.
        for (int n = 0; n < 600; n++) begin
            int m0;
            mr  = ($urandom_range(0, 1) == 1);
            rd  = 4'($urandom_range(0, 3));
            rs  = 4'($urandom_range(0, 3));
            rt  = 4'($urandom_range(0, 3));
            urt = ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 3) == 0);
            hlt = ($urandom_range(0, 40) == 0);
            if (!dm) dm = ($urandom_range(0, 9) == 0);
            if (!im) im = ($urandom_range(0, 9) == 0);
            done = ($urandom_range(0, 3) == 0);
            m0 = m_mode;
            cycle("rand");
            n_tests++;
            if (obs[8] && obs[7]) begin
                n_fail++;
                $display("FAIL rand_grant_onehot: got gi=%b gd=%b required not both", obs[8], obs[7]);
            end
            if (done && m0 == 1) dm = 0;
            if (done && m0 == 2) im = 0;
            if (m_mode == 3 && $urandom_range(0, 3) == 0) begin
                clr_in();
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
